// File: rtl/enc_dec_pkg.sv
// rtl/enc_dec_pkg.sv - register offsets, FSM states and width codes for the encoder control block
package enc_dec_pkg;

  // Word offsets, i.e. PADDR[4:2]
  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_DATA   = 3'd1;
  localparam logic [2:0] OFF_WIDTH  = 3'd2;
  localparam logic [2:0] OFF_RESULT = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;

  localparam logic [1:0] W8  = 2'b00;
  localparam logic [1:0] W16 = 2'b01;
  localparam logic [1:0] W32 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CAPT = 2'd2
  } state_t;

  // The reserved code 11 is kept in WIDTH but the encoder sees an 8-bit request
  function automatic logic [1:0] width_to_enc(input logic [1:0] code);
    case (code)
      W16:     return W16;
      W32:     return W32;
      default: return W8;
    endcase
  endfunction

endpackage

// File: rtl/enc_apb_if.sv
// rtl/enc_apb_if.sv - APB3 decode into write/read strobes and a word offset
module enc_apb_if #(
  parameter int AMBA_ADDR_WIDTH = 20
) (
  input  logic                       psel_i,
  input  logic                       penable_i,
  input  logic                       pwrite_i,
  input  logic [AMBA_ADDR_WIDTH-1:0] paddr_i,
  output logic                       wr_en_o,
  output logic                       rd_en_o,
  output logic [2:0]                 offset_o
);

  logic unused_addr_bits;

  // Writes land in the access phase; reads are fetched in the setup phase
  assign wr_en_o  = psel_i & penable_i & pwrite_i;
  assign rd_en_o  = psel_i & ~penable_i & ~pwrite_i;
  assign offset_o = paddr_i[4:2];

  assign unused_addr_bits = ^{paddr_i[AMBA_ADDR_WIDTH-1:5], paddr_i[1:0]};

endmodule

// File: rtl/enc_ctrl_regs.sv
// rtl/enc_ctrl_regs.sv - APB register file and IDLE/CALC/CAPT sequencer driving the encoder
// ENC_CTRL_RDBACK_EN: when defined, DATA_IN and WIDTH read back their stored values.
module enc_ctrl_regs
  import enc_dec_pkg::*;
#(
  parameter int AMBA_WORD       = 32,
  parameter int AMBA_ADDR_WIDTH = 20,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [AMBA_WORD-1:0]       PWDATA,
  output logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       enc_ena,
  output logic [1:0]                 enc_width,
  output logic [AMBA_WORD-1:0]       enc_data,
  input  logic [DATA_WIDTH-1:0]      enc_codeword,
  output logic                       op_done
);

  state_t               state_q, state_d;
  logic [AMBA_WORD-1:0] data_in_q, data_in_d;
  logic [1:0]           width_q, width_d;
  logic [AMBA_WORD-1:0] result_q, result_d;
  logic                 wr_err_q, wr_err_d;
  logic [AMBA_WORD-1:0] enc_data_q, enc_data_d;
  logic [1:0]           enc_width_q, enc_width_d;
  logic [AMBA_WORD-1:0] prdata_q, prdata_d;

  logic                 wr_en;
  logic                 rd_en;
  logic [2:0]           offset;
  logic                 busy;
  logic [AMBA_WORD-1:0] rd_mux;
  logic [AMBA_WORD-1:0] codeword_w;

  enc_apb_if #(
    .AMBA_ADDR_WIDTH(AMBA_ADDR_WIDTH)
  ) u_apb_if (
    .psel_i   (PSEL),
    .penable_i(PENABLE),
    .pwrite_i (PWRITE),
    .paddr_i  (PADDR),
    .wr_en_o  (wr_en),
    .rd_en_o  (rd_en),
    .offset_o (offset)
  );

  // Fit the encoder result into the register word
  generate
    if (DATA_WIDTH >= AMBA_WORD) begin : g_cw_trunc
      assign codeword_w = enc_codeword[AMBA_WORD-1:0];
    end else begin : g_cw_ext
      assign codeword_w = {{(AMBA_WORD-DATA_WIDTH){1'b0}}, enc_codeword};
    end
  endgenerate

  assign busy = (state_q != IDLE);

  always_comb begin
    rd_mux = '0;
    case (offset)
`ifdef ENC_CTRL_RDBACK_EN
      OFF_DATA:   rd_mux = data_in_q;
      OFF_WIDTH:  rd_mux = {{(AMBA_WORD-2){1'b0}}, width_q};
`endif
      OFF_RESULT: rd_mux = result_q;
      OFF_STATUS: rd_mux = {{(AMBA_WORD-2){1'b0}}, wr_err_q, busy};
      default:    rd_mux = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    data_in_d   = data_in_q;
    width_d     = width_q;
    result_d    = result_q;
    wr_err_d    = wr_err_q;
    enc_data_d  = enc_data_q;
    enc_width_d = enc_width_q;
    prdata_d    = prdata_q;

    case (state_q)
      CALC:    state_d = CAPT;
      CAPT: begin
        state_d  = IDLE;
        result_d = codeword_w;
      end
      default: state_d = IDLE;
    endcase

    // Any write while an operation is in flight is dropped and flagged
    if (wr_en) begin
      if (busy) begin
        wr_err_d = 1'b1;
      end else begin
        case (offset)
          OFF_CTRL: begin
            if (PWDATA[0]) begin
              state_d     = CALC;
              enc_data_d  = data_in_q;
              enc_width_d = width_to_enc(width_q);
            end
          end
          OFF_DATA:   data_in_d = PWDATA;
          OFF_WIDTH:  width_d   = PWDATA[1:0];
          OFF_STATUS: if (PWDATA[1]) wr_err_d = 1'b0;
          default: ;
        endcase
      end
    end

    if (rd_en) prdata_d = rd_mux;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      data_in_q   <= '0;
      width_q     <= '0;
      result_q    <= '0;
      wr_err_q    <= 1'b0;
      enc_data_q  <= '0;
      enc_width_q <= W8;
      prdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      data_in_q   <= data_in_d;
      width_q     <= width_d;
      result_q    <= result_d;
      wr_err_q    <= wr_err_d;
      enc_data_q  <= enc_data_d;
      enc_width_q <= enc_width_d;
      prdata_q    <= prdata_d;
    end
  end

  assign PRDATA    = prdata_q;
  assign enc_ena   = (state_q == CALC);
  assign op_done   = (state_q == CAPT);
  assign enc_data  = enc_data_q;
  assign enc_width = enc_width_q;

endmodule

// File: tb/tb_enc_ctrl_regs.sv
// tb/tb_enc_ctrl_regs.sv - randomized and directed self-checking bench for enc_ctrl_regs
module tb_enc_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] PADDR = '0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PWDATA = '0;
  logic [31:0] PRDATA;
  logic        enc_ena;
  logic [1:0]  enc_width;
  logic [31:0] enc_data;
  logic [31:0] enc_codeword;
  logic        op_done;

  int checks = 0;
  int failures = 0;
  int op_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  // Stand-in encoder: masks the data to the requested width and tags it
  function automatic logic [31:0] fake_enc(input logic [31:0] d, input logic [1:0] w);
    logic [31:0] mask;
    mask = (w == 2'b00) ? 32'h0000_00FF : (w == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return (d & mask) ^ (32'hA500_0000 | {30'b0, w});
  endfunction

  assign enc_codeword = fake_enc(enc_data, enc_width);

  enc_ctrl_regs #(
    .AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32)
  ) dut (
    .clk(clk), .rst(rst), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA), .enc_ena(enc_ena),
    .enc_width(enc_width), .enc_data(enc_data), .enc_codeword(enc_codeword),
    .op_done(op_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference model: registers as plain variables, operation as a countdown of busy cycles
  logic [31:0] m_data, m_result, m_prdata, m_enc_data;
  logic [1:0]  m_width, m_enc_width;
  logic        m_wr_err;
  int          m_busy_left;

  function automatic logic [31:0] m_read(input logic [2:0] off);
    case (off)
`ifdef ENC_CTRL_RDBACK_EN
      3'd1: return m_data;
      3'd2: return {30'b0, m_width};
`endif
      3'd3: return m_result;
      3'd4: return {30'b0, m_wr_err, (m_busy_left > 0)};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= '0; m_result <= '0; m_prdata <= '0; m_enc_data <= '0;
      m_width <= '0; m_enc_width <= '0; m_wr_err <= 1'b0; m_busy_left <= 0;
    end else begin
      if (PSEL && PENABLE && PWRITE) begin
        if (m_busy_left > 0) m_wr_err <= 1'b1;
        else case (PADDR[4:2])
          3'd0: if (PWDATA[0]) begin
            m_busy_left <= 2;
            m_enc_data  <= m_data;
            m_enc_width <= (m_width == 2'b11) ? 2'b00 : m_width;
          end
          3'd1: m_data <= PWDATA;
          3'd2: m_width <= PWDATA[1:0];
          3'd4: if (PWDATA[1]) m_wr_err <= 1'b0;
          default: ;
        endcase
      end
      if (m_busy_left > 0) m_busy_left <= m_busy_left - 1;
      if (m_busy_left == 1) m_result <= fake_enc(m_enc_data, m_enc_width);
      if (PSEL && !PENABLE && !PWRITE) m_prdata <= m_read(PADDR[4:2]);
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("prdata", PRDATA, m_prdata);
      check("enc_ena", {31'b0, enc_ena}, {31'b0, (m_busy_left == 2)});
      check("op_done", {31'b0, op_done}, {31'b0, (m_busy_left == 1)});
      check("enc_data", enc_data, m_enc_data);
      check("enc_width", {30'b0, enc_width}, {30'b0, m_enc_width});
      if (op_done) op_cnt++;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apb_write(input logic [2:0] off, input logic [31:0] d);
    logic [19:0] a;
    a = 20'($urandom);
    a[4:2] = off;
    PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_read(input logic [2:0] off, output logic [31:0] d);
    logic [19:0] a;
    a = 20'($urandom);
    a[4:2] = off;
    PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge clk); #1 PENABLE = 1'b1;
    d = PRDATA;
    @(posedge clk); #1 PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_w;
    int cnt0;

    idle(2);
    check("reset_prdata", PRDATA, 32'h0);
    check("reset_enc_ena", {31'b0, enc_ena}, 32'h0);
    check("reset_enc_data", enc_data, 32'h0);
    check("reset_enc_width", {30'b0, enc_width}, 32'h0);
    check("reset_op_done", {31'b0, op_done}, 32'h0);
    rst = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // 8-bit encode of 0x0F
    apb_write(3'd1, 32'h0000_000F);
    apb_write(3'd2, 32'h0);
    apb_write(3'd0, 32'h1);
    check("calc_enc_ena", {31'b0, enc_ena}, 32'h1);
    check("calc_enc_data", enc_data, 32'h0000_000F);
    check("calc_op_done", {31'b0, op_done}, 32'h0);
    idle(1);
    check("capt_op_done", {31'b0, op_done}, 32'h1);
    check("capt_enc_ena", {31'b0, enc_ena}, 32'h0);
    idle(1);
    apb_read(3'd3, rd);
    check("result_8bit", rd, 32'hA500_000F);

    // Back-to-back starts: second is dropped and flagged
    cnt0 = op_cnt;
    apb_write(3'd0, 32'h1);
    apb_write(3'd0, 32'h1);
    idle(3);
    check("b2b_op_count", 32'(op_cnt - cnt0), 32'h1);
    apb_read(3'd4, rd);
    check("b2b_status", rd, 32'h2);
    apb_write(3'd4, 32'h2);
    apb_read(3'd4, rd);
    check("clear_status", rd, 32'h0);

    // Write during an operation is dropped
    apb_write(3'd1, 32'h1234_5678);
    apb_write(3'd0, 32'h1);
    apb_write(3'd1, 32'hFFFF_FFFF);
    check("drop_enc_data", enc_data, 32'h1234_5678);
    apb_read(3'd4, rd);
    check("drop_status_idle", rd, 32'h2);
    apb_write(3'd0, 32'h1);
    apb_read(3'd4, rd);
    check("busy_status", rd, 32'h3);
    check("data_in_kept", enc_data, 32'h1234_5678);
    apb_read(3'd4, rd);
    check("after_status", rd, 32'h2);

    // Reserved width code
    apb_write(3'd2, 32'h3);
    apb_write(3'd0, 32'h1);
    check("width11_enc", {30'b0, enc_width}, 32'h0);
    idle(2);
    apb_read(3'd2, rd);
`ifdef ENC_CTRL_RDBACK_EN
    exp_w = 32'h3;
`else
    exp_w = 32'h0;
`endif
    check("width_readback", rd, exp_w);
    apb_read(3'd5, rd);
    check("unmapped_0x14", rd, 32'h0);
    apb_read(3'd0, rd);
    check("ctrl_reads_0", rd, 32'h0);
    apb_write(3'd4, 32'h2);
    apb_read(3'd4, rd);
    check("status_cleared", rd, 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [2:0] off;
      off = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) apb_write(off, $urandom);
      else apb_read(off, rd);
      idle($urandom_range(0, 2));
    end
    idle(4);

    // Reset in the middle of CALC
    apb_write(3'd1, 32'hDEAD_BEEF);
    apb_write(3'd0, 32'h1);
    cnt0 = op_cnt;
    rst = 1'b0;
    #1;
    check("rst_enc_ena", {31'b0, enc_ena}, 32'h0);
    check("rst_op_done", {31'b0, op_done}, 32'h0);
    check("rst_enc_data", enc_data, 32'h0);
    check("rst_enc_width", {30'b0, enc_width}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    idle(2);
    rst = 1'b1;
    idle(3);
    check("rst_no_op_done", 32'(op_cnt - cnt0), 32'h0);
    apb_read(3'd4, rd);
    check("rst_status", rd, 32'h0);
    apb_read(3'd3, rd);
    check("rst_result", rd, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
